rom_sdr_write_coalescer: RTL and testbench

- Sits between the ROM loader's SDRAM byte-write port and the SDRAM controller's download write channel during ROM download.
- The loader emits one byte per request, with data duplicated on both lanes and a one-hot byte enable.
- This block pairs a low byte with the following high byte of the same word into one 16-bit write. It buffers merged words in a small FIFO, which halves SDRAM write transactions.
- It returns a per-byte ready to the loader and reports when all buffered data has reached SDRAM.

---
 rtl/rom_sdr_write_coalescer.sv | 254 +++++++++++++++++++++++++
 tb/tb_rom_sdr_write_coalescer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_sdr_write_coalescer.sv
// Pairs loader byte writes into 16-bit SDRAM word writes through a small FIFO.
// Optional counters for acked words and partial pushes are enabled by COALESCE_STATS_EN.
module rom_sdr_write_coalescer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [15:0]       in_data,
  input  logic [1:0]        in_be,
  input  logic              in_req,
  output logic              in_rdy,
  input  logic              flush,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic [15:0]       sdr_data,
  output logic [1:0]        sdr_be,
  output logic              sdr_req,
  input  logic              sdr_ack,
  output logic              busy
`ifdef COALESCE_STATS_EN
  ,
  output logic [31:0]       stat_words,
  output logic [31:0]       stat_partial
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WA_W  = ADDR_W - 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic            r_hold_v;
  logic [WA_W-1:0] r_hold_wa;
  logic [15:0]     r_hold_data;
  logic [1:0]      r_hold_be;
  logic            r_pend_flush;
  logic            r_rdy;
  logic            r_guard;

  logic [WA_W-1:0] r_fifo_wa   [FIFO_DEPTH];
  logic [15:0]     r_fifo_data [FIFO_DEPTH];
  logic [1:0]      r_fifo_be   [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [1:0]        r_state;
  logic              r_sdr_req;
  logic [ADDR_W-1:0] r_sdr_addr;
  logic [15:0]       r_sdr_data;
  logic [1:0]        r_sdr_be;
  logic              r_busy;

  logic            w_space;
  logic            w_pend_push;
  logic            w_accept;
  logic            w_same;
  logic [WA_W-1:0] w_in_wa;
  logic            w_push;
  logic [WA_W-1:0] w_push_wa;
  logic [15:0]     w_push_data;
  logic [1:0]      w_push_be;
  logic            w_hold_v_d;
  logic [WA_W-1:0] w_hold_wa_d;
  logic [15:0]     w_hold_data_d;
  logic [1:0]      w_hold_be_d;
  logic            w_pend_d;
  logic            w_pop;
  logic [CNT_W-1:0] w_count_d;
  logic [1:0]      w_state_d;
  logic            w_req_d;
  logic            w_load;
  logic            w_busy_d;
  logic            w_unused_addr0;

  assign w_unused_addr0 = in_addr[0];
  assign w_in_wa        = in_addr[ADDR_W-1:1];
  assign w_space        = (r_count < DEPTH_C);
  // A flush left pending by a full FIFO goes ahead of any new byte once space opens.
  assign w_pend_push    = r_pend_flush & r_hold_v & w_space;
  assign w_accept       = in_req & w_space & ~r_rdy & ~r_guard & ~w_pend_push;
  assign w_same         = r_hold_v && (r_hold_be == 2'b01) && (r_hold_wa == w_in_wa);
  assign w_pop          = (r_state == S_REQ) & sdr_ack;

  always_comb begin
    w_push        = 1'b0;
    w_push_wa     = r_hold_wa;
    w_push_data   = r_hold_data;
    w_push_be     = r_hold_be;
    w_hold_v_d    = r_hold_v;
    w_hold_wa_d   = r_hold_wa;
    w_hold_data_d = r_hold_data;
    w_hold_be_d   = r_hold_be;
    w_pend_d      = r_pend_flush;
    if (w_accept) begin
      // A flush arriving with a byte acts on the hold that byte leaves behind.
      w_pend_d = flush;
      case (in_be)
        2'b01: begin
          w_push        = r_hold_v;
          w_hold_v_d    = 1'b1;
          w_hold_wa_d   = w_in_wa;
          w_hold_data_d = {8'h00, in_data[7:0]};
          w_hold_be_d   = 2'b01;
        end
        2'b10: begin
          if (w_same) begin
            w_push      = 1'b1;
            w_push_data = {in_data[15:8], r_hold_data[7:0]};
            w_push_be   = 2'b11;
            w_hold_v_d  = 1'b0;
          end else begin
            w_push        = r_hold_v;
            w_hold_v_d    = 1'b1;
            w_hold_wa_d   = w_in_wa;
            w_hold_data_d = {in_data[15:8], 8'h00};
            w_hold_be_d   = 2'b10;
          end
        end
        2'b11: begin
          w_push        = r_hold_v;
          w_hold_v_d    = 1'b1;
          w_hold_wa_d   = w_in_wa;
          w_hold_data_d = in_data;
          w_hold_be_d   = 2'b11;
        end
        default: ;
      endcase
    end else if (flush || r_pend_flush) begin
      if (!r_hold_v) begin
        w_pend_d = 1'b0;
      end else if (w_space) begin
        w_push     = 1'b1;
        w_hold_v_d = 1'b0;
        w_pend_d   = 1'b0;
      end else begin
        w_pend_d = 1'b1;
      end
    end
  end

  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + 1'b1;
      2'b01:   w_count_d = r_count - 1'b1;
      default: w_count_d = r_count;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_req_d   = r_sdr_req;
    w_load    = 1'b0;
    case (r_state)
      S_IDLE: if (r_count != '0) begin
        w_state_d = S_REQ;
        w_req_d   = 1'b1;
        w_load    = 1'b1;
      end
      S_REQ: if (sdr_ack) begin
        w_state_d = S_GAP;
        w_req_d   = 1'b0;
      end
      S_GAP:   w_state_d = S_IDLE;
      default: begin
        w_state_d = S_IDLE;
        w_req_d   = 1'b0;
      end
    endcase
  end

  assign w_busy_d = w_hold_v_d | (w_count_d != '0) | w_req_d | w_pend_d;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_wa[r_wr_ptr]   <= w_push_wa;
      r_fifo_data[r_wr_ptr] <= w_push_data;
      r_fifo_be[r_wr_ptr]   <= w_push_be;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_v     <= 1'b0;
      r_hold_wa    <= '0;
      r_hold_data  <= '0;
      r_hold_be    <= '0;
      r_pend_flush <= 1'b0;
      r_rdy        <= 1'b0;
      r_guard      <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_state      <= S_IDLE;
      r_sdr_req    <= 1'b0;
      r_sdr_addr   <= '0;
      r_sdr_data   <= '0;
      r_sdr_be     <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_hold_v     <= w_hold_v_d;
      r_hold_wa    <= w_hold_wa_d;
      r_hold_data  <= w_hold_data_d;
      r_hold_be    <= w_hold_be_d;
      r_pend_flush <= w_pend_d;
      r_rdy        <= w_accept;
      r_guard      <= r_rdy;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count      <= w_count_d;
      r_state      <= w_state_d;
      r_sdr_req    <= w_req_d;
      if (w_load) begin
        r_sdr_addr <= {r_fifo_wa[r_rd_ptr], 1'b0};
        r_sdr_data <= r_fifo_data[r_rd_ptr];
        r_sdr_be   <= r_fifo_be[r_rd_ptr];
      end
      r_busy       <= w_busy_d;
    end
  end

  assign in_rdy   = r_rdy;
  assign sdr_req  = r_sdr_req;
  assign sdr_addr = r_sdr_addr;
  assign sdr_data = r_sdr_data;
  assign sdr_be   = r_sdr_be;
  assign busy     = r_busy;

`ifdef COALESCE_STATS_EN
  logic [31:0] r_stat_words;
  logic [31:0] r_stat_partial;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_words   <= '0;
      r_stat_partial <= '0;
    end else begin
      if (w_pop && (r_stat_words != 32'hFFFF_FFFF)) r_stat_words <= r_stat_words + 1'b1;
      if (w_push && (w_push_be != 2'b11) && (r_stat_partial != 32'hFFFF_FFFF)) begin
        r_stat_partial <= r_stat_partial + 1'b1;
      end
    end
  end

  assign stat_words   = r_stat_words;
  assign stat_partial = r_stat_partial;
`endif

endmodule

// File: tb/tb_rom_sdr_write_coalescer.sv
// Self-checking bench: directed scenarios plus randomized byte streams scored against
// a byte-pairing reference model; writes are checked as the bench acknowledges them.
module tb_rom_sdr_write_coalescer;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned ADDR_W     = 25;
  localparam int MAX_WAIT = 400;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] in_addr;
  logic [15:0]       in_data;
  logic [1:0]        in_be;
  logic              in_req;
  logic              in_rdy;
  logic              flush;
  logic [ADDR_W-1:0] sdr_addr;
  logic [15:0]       sdr_data;
  logic [1:0]        sdr_be;
  logic              sdr_req;
  logic              sdr_ack;
  logic              busy;

  rom_sdr_write_coalescer #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_addr (in_addr),
    .in_data (in_data),
    .in_be   (in_be),
    .in_req  (in_req),
    .in_rdy  (in_rdy),
    .flush   (flush),
    .sdr_addr(sdr_addr),
    .sdr_data(sdr_data),
    .sdr_be  (sdr_be),
    .sdr_req (sdr_req),
    .sdr_ack (sdr_ack),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic [1:0]        be;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;

  // Reference model of the loader-side pairing rules.
  logic              m_hold_v;
  logic [ADDR_W-2:0] m_hold_wa;
  logic [15:0]       m_hold_data;
  logic [1:0]        m_hold_be;

  int n_vec;
  int n_err;
  int n_writes;
  bit ack_en;
  int ack_gap;
  int ack_wait;

  task automatic m_push(input logic [ADDR_W-2:0] wa, input logic [15:0] d, input logic [1:0] be);
    wr_t w;
    w.addr = {wa, 1'b0};
    w.data = d;
    w.be   = be;
    exp_q.push_back(w);
  endtask

  task automatic m_load(input logic [ADDR_W-2:0] wa, input logic [15:0] d, input logic [1:0] be);
    if (m_hold_v) m_push(m_hold_wa, m_hold_data, m_hold_be);
    m_hold_v    = 1'b1;
    m_hold_wa   = wa;
    m_hold_data = d;
    m_hold_be   = be;
  endtask

  task automatic m_byte(input logic [ADDR_W-1:0] a, input logic [15:0] d, input logic [1:0] be);
    logic [ADDR_W-2:0] wa;
    wa = a[ADDR_W-1:1];
    if (be == 2'b01) m_load(wa, {8'h00, d[7:0]}, 2'b01);
    else if (be == 2'b10) begin
      if (m_hold_v && m_hold_be == 2'b01 && m_hold_wa == wa) begin
        m_push(wa, {d[15:8], m_hold_data[7:0]}, 2'b11);
        m_hold_v = 1'b0;
      end else m_load(wa, {d[15:8], 8'h00}, 2'b10);
    end else if (be == 2'b11) m_load(wa, d, 2'b11);
  endtask

  task automatic m_flush();
    if (m_hold_v) m_push(m_hold_wa, m_hold_data, m_hold_be);
    m_hold_v = 1'b0;
  endtask

  // SDRAM side: acknowledge requests and score each write against the model.
  initial begin
    sdr_ack  = 1'b0;
    ack_wait = 0;
    forever begin
      @(negedge clk);
      sdr_ack = 1'b0;
      if (ack_en && sdr_req && !reset) begin
        if (ack_wait >= ack_gap) begin
          ack_wait = 0;
          sdr_ack  = 1'b1;
          n_writes++;
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL write_unexpected: got addr=%h data=%h be=%b, required no write",
                     sdr_addr, sdr_data, sdr_be);
          end else begin
            e = exp_q.pop_front();
            if ({sdr_addr, sdr_data, sdr_be} !== {e.addr, e.data, e.be}) begin
              n_err++;
              $display("FAIL write_content: got addr=%h data=%h be=%b, required addr=%h data=%h be=%b",
                       sdr_addr, sdr_data, sdr_be, e.addr, e.data, e.be);
            end
          end
        end else ack_wait++;
      end
    end
  end

  task automatic send_byte(input logic [ADDR_W-1:0] a, input logic [15:0] d, input logic [1:0] be,
                           input bit with_flush);
    bit ok;
    @(negedge clk);
    m_byte(a, d, be);
    in_addr = a;
    in_data = d;
    in_be   = be;
    in_req  = 1'b1;
    if (with_flush) begin
      flush = 1'b1;
      m_flush();
    end
    ok = 1'b0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk);
      flush = 1'b0;
      if (in_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_req = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL accept_timeout: in_rdy=0 after %0d cycles for addr=%h, required 1", MAX_WAIT, a);
    end
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    flush = 1'b1;
    m_flush();
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000; i++) begin
      if (busy === 1'b0 && exp_q.size() == 0) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    in_addr = '0;
    in_data = '0;
    in_be   = '0;
    in_req  = 1'b0;
    flush   = 1'b0;
    m_hold_v = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({in_rdy, sdr_req, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_ctrl: rdy/req/busy=%b, required 000", {in_rdy, sdr_req, busy});
    end
    n_vec++;
    if (sdr_addr !== '0) begin
      n_err++;
      $display("FAIL reset_addr: sdr_addr=%h, required 0", sdr_addr);
    end
    n_vec++;
    if ({sdr_data, sdr_be} !== 18'h0) begin
      n_err++;
      $display("FAIL reset_data: data=%h be=%b, required 0/00", sdr_data, sdr_be);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_pair();
    int w0;
    ack_en = 1'b1; ack_gap = 0; w0 = n_writes;
    send_byte(25'h000100, 16'h1212, 2'b01, 1'b0);
    send_byte(25'h000101, 16'h3434, 2'b10, 1'b0);
    flush_pulse();
    wait_drain();
    n_vec++;
    if (n_writes - w0 != 1 || busy !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pair: writes=%0d busy=%b left=%0d, required 1/0/0",
               n_writes - w0, busy, exp_q.size());
    end
  endtask

  task automatic test_two_lows();
    int w0;
    w0 = n_writes;
    send_byte(25'h000200, 16'hAAAA, 2'b01, 1'b0);
    send_byte(25'h000300, 16'hBBBB, 2'b01, 1'b0);
    flush_pulse();
    wait_drain();
    n_vec++;
    if (n_writes - w0 != 2 || busy !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL two_lows: writes=%0d busy=%b left=%0d, required 2/0/0",
               n_writes - w0, busy, exp_q.size());
    end
  endtask

  task automatic test_lone_high();
    int w0;
    w0 = n_writes;
    send_byte(25'h000401, 16'hCCCC, 2'b10, 1'b0);
    flush_pulse();
    wait_drain();
    n_vec++;
    if (n_writes - w0 != 1 || busy !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL lone_high: writes=%0d busy=%b left=%0d, required 1/0/0",
               n_writes - w0, busy, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int w0;
    int accepted;
    bit stalled;
    bit ok;
    logic [7:0] b;
    ack_en = 1'b0; ack_gap = 0; w0 = n_writes; accepted = 0; stalled = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      b = 8'(8'h40 + k);
      in_addr = 25'h001000 + 25'(k);
      in_data = {b, b};
      in_be   = k[0] ? 2'b10 : 2'b01;
      in_req  = 1'b1;
      m_byte(in_addr, in_data, in_be);
      ok = 1'b0;
      for (int i = 0; i < MAX_WAIT; i++) begin
        @(negedge clk);
        if (!ack_en && i == 40) begin
          stalled = 1'b1;
          n_vec++;
          if (accepted != 2 * FIFO_DEPTH || busy !== 1'b1) begin
            n_err++;
            $display("FAIL stall_point: accepted=%0d busy=%b, required %0d/1",
                     accepted, busy, 2 * FIFO_DEPTH);
          end
          ack_en = 1'b1;
        end
        if (in_rdy) begin
          ok = 1'b1;
          break;
        end
      end
      in_req = 1'b0;
      if (ok) accepted++;
    end
    ack_en = 1'b1;
    n_vec++;
    if (!stalled || accepted != 12) begin
      n_err++;
      $display("FAIL backpressure: stalled=%b accepted=%0d, required 1/12", stalled, accepted);
    end
    flush_pulse();
    wait_drain();
    n_vec++;
    if (n_writes - w0 != 6 || busy !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain6: writes=%0d busy=%b left=%0d, required 6/0/0",
               n_writes - w0, busy, exp_q.size());
    end
  endtask

  task automatic test_reset_midop();
    int w0;
    ack_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      send_byte(25'h001800 + 25'(k), {2{8'(8'h60 + k)}}, k[0] ? 2'b10 : 2'b01, 1'b0);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (sdr_req !== 1'b1) begin
      n_err++;
      $display("FAIL midop_pre: sdr_req=%b, required 1", sdr_req);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({sdr_req, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL midop_reset: req/busy=%b, required 00", {sdr_req, busy});
    end
    exp_q.delete();
    m_hold_v = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ack_en = 1'b1;
    w0 = n_writes;
    repeat (20) @(negedge clk);
    n_vec++;
    if (n_writes != w0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midop_quiet: writes=%0d busy=%b, required 0/0", n_writes - w0, busy);
    end
    send_byte(25'h002000, 16'h7777, 2'b01, 1'b0);
    send_byte(25'h002001, 16'h8888, 2'b10, 1'b0);
    wait_drain();
    n_vec++;
    if (n_writes - w0 != 1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL midop_after: writes=%0d left=%0d, required 1/0", n_writes - w0, exp_q.size());
    end
  endtask

  task automatic test_flush_with_accept();
    int w0;
    ack_en = 1'b1; ack_gap = 1; w0 = n_writes;
    repeat (4) @(negedge clk);
    send_byte(25'h000500, 16'h5555, 2'b01, 1'b1);
    wait_drain();
    n_vec++;
    if (n_writes - w0 != 1 || busy !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL flush_accept: writes=%0d busy=%b left=%0d, required 1/0/0",
               n_writes - w0, busy, exp_q.size());
    end
  endtask

  task automatic test_random();
    logic [ADDR_W-2:0] wa;
    logic [1:0]        be;
    logic [7:0]        b;
    logic [15:0]       d;
    logic              lsb;
    ack_en = 1'b1;
    for (int k = 0; k < 80; k++) begin
      ack_gap = int'($urandom_range(0, 3));
      wa  = 24'h001800 + 24'($urandom_range(0, 3));
      be  = 2'($urandom_range(0, 3));
      b   = 8'($urandom);
      d   = (be == 2'b11) ? 16'($urandom) : {b, b};
      lsb = (be == 2'b10) ? 1'b1 : ((be == 2'b00) ? 1'($urandom) : 1'b0);
      if ($urandom_range(0, 9) == 0) begin
        wait_drain();
        repeat (3) @(negedge clk);
        send_byte({wa, lsb}, d, be, 1'b1);
      end else begin
        send_byte({wa, lsb}, d, be, 1'b0);
        if ($urandom_range(0, 7) == 0) flush_pulse();
      end
    end
    flush_pulse();
    wait_drain();
    n_vec++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL random_drain: busy=%b left=%0d, required 0/0", busy, exp_q.size());
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_writes = 0; ack_en = 1'b0; ack_gap = 0;
    test_reset();
    test_pair();
    test_two_lows();
    test_lone_high();
    test_back_to_back();
    test_reset_midop();
    test_flush_with_accept();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
